// File: rtl/aes_pkg.sv
// Shared definitions for the AES-CTR job sequencer: FSM encodings, datapath
// widths and the counter-block builder.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned NONCE_W   = 96;
    localparam int unsigned CTR_W     = 32;

    localparam logic [CTR_W-1:0] CTR_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

    // CTR-mode counter block: nonce in the upper 96 bits, counter below.
    function automatic logic [AES_BLK_W-1:0] make_ctr_block(
        input logic [NONCE_W-1:0] nonce,
        input logic [CTR_W-1:0]   ctr
    );
        return {nonce, ctr};
    endfunction

endpackage

// File: rtl/aes_ctr_sequencer.sv
// AES-128 CTR-mode job sequencer. Accepts plaintext blocks on a valid/ready
// stream, issues one counter block at a time to the encryptor and returns
// plaintext ^ keystream on a valid/ready output stream. Engine faults and
// counter exhaustion park the block in a sticky error state until reloaded.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_load/key/nonce/ctr       configuration load (idle only, clears error)
//   in_valid/ready/data/last     plaintext input stream
//   eng_start/key/block          job issue to the encryptor
//   eng_busy/done/ct/fault       encryptor status and result
//   out_valid/ready/data/last    result output stream
//   out_fault                    block was corrupted by an engine fault
//   configured, error            status
module aes_ctr_sequencer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [KEY_W-1:0]     cfg_key,
    input  logic [NONCE_W-1:0]   cfg_nonce,
    input  logic [CTR_W-1:0]     cfg_ctr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 eng_start,
    output logic [KEY_W-1:0]     eng_key,
    output logic [AES_BLK_W-1:0] eng_block,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic [AES_BLK_W-1:0] eng_ct,
    input  logic                 eng_fault,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic                 out_fault,
    output logic                 configured,
    output logic                 error
);

    seq_state_t           state;
    logic [AES_BLK_W-1:0] data_q;
    logic                 last_q;

    // eng_block doubles as the nonce/counter storage; the counter is its low word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            data_q     <= '0;
            last_q     <= 1'b0;
            in_ready   <= 1'b0;
            eng_start  <= 1'b0;
            eng_key    <= '0;
            eng_block  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_fault  <= 1'b0;
            configured <= 1'b0;
            error      <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= ST_ISSUE;
                    end else if (cfg_load && !in_valid) begin
                        eng_key    <= cfg_key;
                        eng_block  <= make_ctr_block(cfg_nonce, cfg_ctr);
                        configured <= 1'b1;
                        error      <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        out_valid <= 1'b1;
                        out_last  <= last_q;
                        if (eng_fault) begin
                            out_data  <= '0;
                            out_fault <= 1'b1;
                            error     <= 1'b1;
                        end else begin
                            out_data  <= data_q ^ eng_ct;
                            out_fault <= 1'b0;
                        end
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_fault) begin
                            state <= ST_ERROR;
                        end else if (eng_block[CTR_W-1:0] == CTR_MAX) begin
                            // Counter never wraps: stop rather than reuse a block.
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            eng_block[CTR_W-1:0] <= eng_block[CTR_W-1:0] + CTR_W'(1);
                            in_ready             <= 1'b1;
                            state                <= ST_IDLE;
                        end
                    end
                end
                ST_ERROR: begin
                    if (cfg_load) begin
                        eng_key    <= cfg_key;
                        eng_block  <= make_ctr_block(cfg_nonce, cfg_ctr);
                        configured <= 1'b1;
                        error      <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_ctr_sequencer.md
# aes_ctr_sequencer

Upstream job sequencer for the AES-128 encryptor: accepts a valid/ready stream of 128-bit data blocks and builds CTR-mode counter blocks from a programmed 96-bit nonce and 32-bit counter. It issues one encryption at a time to the encryptor's start/busy/done/ciphertext/fault_flag port, XORs the returned keystream with the buffered data block and emits the result on a valid/ready output stream. Encryptor faults propagate to the stream as a sticky error.

## Interface
- No parameters; key 128 b, nonce 96 b, counter 32 b are fixed.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_load  in  1  load key/nonce/counter; honoured only in ST_IDLE with in_valid low; clears error.
- cfg_key  in  128  AES-128 key.
- cfg_nonce  in  96  nonce (counter block bits 127:32).
- cfg_ctr  in  32  initial counter (bits 31:0).
- in_valid / in_ready  in / out  1  input handshake; beat transfers when both are high.
- in_data  in  128  plaintext block.
- in_last  in  1  final block of message.
- eng_start  out  1  one-cycle pulse to the encryptor.
- eng_key  out  128  registered key; held stable while a job is outstanding.
- eng_block  out  128  counter block {nonce, ctr}; held stable while a job is outstanding.
- eng_busy  in  1  encryptor busy.
- eng_done  in  1  encryptor completion pulse.
- eng_ct  in  128  encryptor ciphertext (keystream).
- eng_fault  in  1  encryptor fault flag, qualified by eng_done.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  128  data XOR keystream, or 0 on fault.
- out_last  out  1  copy of in_last for this block.
- out_fault  out  1  this block was corrupted by an engine fault.
- configured  out  1  cfg_load accepted since reset.
- error  out  1  sticky; set by a fault or counter exhaustion.

## Operation
- States: ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT, ST_ERROR.
- **ST_IDLE**
  - in_ready = configured & ~error.
  - On an accepted beat: latch in_data and in_last, go to ST_ISSUE.
  - If cfg_load and in_valid are both high, cfg_load is ignored.
- **ST_ISSUE**
  - When eng_busy is low: pulse eng_start for one cycle, go to ST_WAIT.
  - Otherwise hold in ST_ISSUE.
- **ST_WAIT**
  - On eng_done with eng_fault=0: out_data <= data ^ eng_ct, out_fault <= 0, go to ST_OUT.
  - On eng_done with eng_fault=1: out_data <= 0, out_fault <= 1, error <= 1, go to ST_OUT.
  - No timeout.
- **ST_OUT**
  - out_valid high until out_ready.
  - On handshake:
    - If out_fault: go to ST_ERROR.
    - Else if ctr == 32'hFFFFFFFF: set error, go to ST_ERROR. The counter never wraps.
    - Else: ctr <= ctr + 1 (modulo 2^32), go to ST_IDLE.
- **ST_ERROR**
  - in_ready = 0.
  - Only cfg_load leaves this state: reload registers, clear error, go to ST_IDLE.
- **Counter after in_last**
  - ctr continues incrementing; there is no reset on message boundaries.
  - Software must reload the nonce per message.
- **Reset values**
  - state ST_IDLE; all outputs 0: eng_start, in_ready, out_valid, out_data, out_last, out_fault, configured, error, eng_key, eng_block.
- **Reset mid-job**
  - Abandons the job with no output beat.
  - An encryptor eng_done arriving after reset is ignored (state is ST_IDLE).

## Timing
- Input acceptance to eng_start: 1 cycle if the engine is idle.
- eng_done to out_valid: 1 cycle (registered).
- Blocks do not overlap: the next in_ready comes the cycle after the output handshake.
- Throughput: one block per (engine latency + 3) cycles, minimum.
- out_data, out_last and out_fault are stable while out_valid && !out_ready.
- eng_key and eng_block change only on cfg_load or on the counter increment, never between eng_start and eng_done.

## Structure
- Shared package aes_pkg holds:
  - state encodings;
  - widths: AES_BLK_W=128, NONCE_W=96, CTR_W=32;
  - CTR_MAX=32'hFFFFFFFF.
- Single module, no sub-module.
- The top level connects it to the encryptor: eng_start→start, eng_key→key, eng_block→plaintext, busy/done/ciphertext/fault_flag→eng_*.

## Test plan
- **SP 800-38A F.5.1 vectors.** key 2b7e151628aed2a6abf7158809cf4f3c, nonce f0f1f2f3f4f5f6f7f8f9fafb, ctr fcfdfeff. Send two blocks, out_ready held high:
  - in 6bc1bee22e409f96e93d7e117393172a → out 874d6191b620e3261bef6864990db6ce.
  - in ae2d8a571e03ac9c9eb76fac45af8e51 → out 9806f66b7970fdff8617187bb9fffdff; eng_block low word fcfdff00.
- **Output backpressure.** Hold out_ready=0 for 20 cycles → out_data, out_last and out_valid stay stable, in_ready=0, no second eng_start.
- **Fault injection.** Model asserts eng_fault with eng_done → out_data=0, out_fault=1, error=1. Then in_ready stays 0 until cfg_load, after which a good block encrypts correctly.
- **Counter exhaustion.** Load ctr=FFFFFFFF, send one block → correct output, then error=1 and in_ready=0; eng_block is never issued with ctr 00000000.
- **Reset mid-job.** Assert rst during ST_WAIT → all outputs 0 next cycle; a late eng_done produces no out_valid.
- **Config guards.** cfg_load while in_valid=1 in ST_IDLE, or while in ST_WAIT → ignored; eng_key and eng_block unchanged.
